// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I integer ALU.
// The op encoding follows the {funct7[5], funct3} layout of the base ISA.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101,
        ALU_LUI  = 4'b1111
    } alu_op_e;

    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] value);
        logic [DATA_W-1:0] result;
        for (int i = 0; i < DATA_W; i++) begin
            result[i] = value[DATA_W-1-i];
        end
        return result;
    endfunction

endpackage

// File: rtl/rv32i_alu_addsub.sv
// Shared 33-bit adder for ADD, SUB, SLT and SLTU.
// Subtraction is a + ~b + 1, so the carry-out directly gives the unsigned compare.
module rv32i_alu_addsub
    import alu_pkg::*;
(
    input  logic              i_sub,
    input  logic [DATA_W-1:0] i_operand_a,
    input  logic [DATA_W-1:0] i_operand_b,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_carry,
    output logic              o_lt,
    output logic              o_ltu
);

    logic [DATA_W-1:0] operand_b_eff;
    logic [DATA_W:0]   sum_full;

    assign operand_b_eff = i_sub ? ~i_operand_b : i_operand_b;
    assign sum_full      = {1'b0, i_operand_a} + {1'b0, operand_b_eff}
                         + {{DATA_W{1'b0}}, i_sub};

    assign o_sum   = sum_full[DATA_W-1:0];
    assign o_carry = sum_full[DATA_W];

    // A borrow (no carry-out) means a < b unsigned; on sign mismatch the negative operand is smaller.
    assign o_ltu = ~o_carry;
    assign o_lt  = (i_operand_a[DATA_W-1] != i_operand_b[DATA_W-1]) ? i_operand_a[DATA_W-1]
                                                                     : o_sum[DATA_W-1];

endmodule

// File: rtl/rv32i_alu.sv
// RV32I integer ALU: combinational result plus a registered debug/pipeline tap.
// Shifts share one right barrel shifter; SLL reverses bits around it.
module rv32i_alu
    import alu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [3:0]        i_alu_op,
    input  logic [DATA_W-1:0] i_operand_a,
    input  logic [DATA_W-1:0] i_operand_b,
    output logic [DATA_W-1:0] o_alu_data,
    output logic [DATA_W-1:0] o_alu_data_q
);

    alu_op_e           alu_op;
    logic              use_sub;
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic              lt;
    logic              ltu;

    logic [SHAMT_W-1:0] shamt;
    logic               shift_fill;
    logic [DATA_W-1:0]  shift_in;
    logic [DATA_W-1:0]  shift_s0;
    logic [DATA_W-1:0]  shift_s1;
    logic [DATA_W-1:0]  shift_s2;
    logic [DATA_W-1:0]  shift_s3;
    logic [DATA_W-1:0]  shift_s4;

    logic [DATA_W-1:0] alu_data_d;
    logic [DATA_W-1:0] alu_data_q;

    assign alu_op  = alu_op_e'(i_alu_op);
    assign use_sub = (alu_op != ALU_ADD);

    rv32i_alu_addsub u_addsub (
        .i_sub       (use_sub),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .o_sum       (sum),
        .o_carry     (carry),
        .o_lt        (lt),
        .o_ltu       (ltu)
    );

    assign shamt      = i_operand_b[SHAMT_W-1:0];
    assign shift_fill = (alu_op == ALU_SRA) & i_operand_a[DATA_W-1];
    assign shift_in   = (alu_op == ALU_SLL) ? bit_reverse(i_operand_a) : i_operand_a;

    assign shift_s0 = shamt[0] ? {shift_fill,         shift_in[DATA_W-1:1]}  : shift_in;
    assign shift_s1 = shamt[1] ? {{2{shift_fill}},    shift_s0[DATA_W-1:2]}  : shift_s0;
    assign shift_s2 = shamt[2] ? {{4{shift_fill}},    shift_s1[DATA_W-1:4]}  : shift_s1;
    assign shift_s3 = shamt[3] ? {{8{shift_fill}},    shift_s2[DATA_W-1:8]}  : shift_s2;
    assign shift_s4 = shamt[4] ? {{16{shift_fill}},   shift_s3[DATA_W-1:16]} : shift_s3;

    always_comb begin
        // NOTE: the default assignment before the case keeps this block free of inferred latches.
        alu_data_d = '0;
        case (alu_op)
            ALU_ADD,
            ALU_SUB:  alu_data_d = sum;
            ALU_SLT:  alu_data_d = {{(DATA_W-1){1'b0}}, lt};
            ALU_SLTU: alu_data_d = {{(DATA_W-1){1'b0}}, ltu};
            ALU_SLL:  alu_data_d = bit_reverse(shift_s4);
            ALU_SRL,
            ALU_SRA:  alu_data_d = shift_s4;
            ALU_XOR:  alu_data_d = i_operand_a ^ i_operand_b;
            ALU_OR:   alu_data_d = i_operand_a | i_operand_b;
            ALU_AND:  alu_data_d = i_operand_a & i_operand_b;
            ALU_LUI:  alu_data_d = i_operand_b;
            default:  alu_data_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!i_rst_n) begin
            alu_data_q <= '0;
        end else begin
            alu_data_q <= alu_data_d;
        end
    end

    assign o_alu_data   = alu_data_d;
    assign o_alu_data_q = alu_data_q;

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: directed corner cases, a mid-run reset,
// and a randomized sweep of all 16 op codes against an arithmetic reference model.
module tb_rv32i_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] alu_data;
    logic [31:0] alu_data_q;

    int n_tests;
    int n_fail;

    rv32i_alu dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_alu_op     (alu_op),
        .i_operand_a  (operand_a),
        .i_operand_b  (operand_b),
        .o_alu_data   (alu_data),
        .o_alu_data_q (alu_data_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << sh;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return $unsigned($signed(a) >>> sh);
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1111: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one vector away from the rising edge, check the combinational result,
    // then check the registered copy one edge later.
    task automatic run_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expected);
        @(negedge clk);
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        #1;
        check(tag, alu_data, expected);
        @(posedge clk);
        #1;
        check({tag, "_q"}, alu_data_q, expected);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [8];
        corners = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000,
                    32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0020, 32'hFFFF_FFE1};
        if ($urandom_range(0, 3) == 0) begin
            return corners[$urandom_range(0, 7)];
        end
        return $urandom;
    endfunction

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        logic [3:0]  op;

        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        alu_op    = 4'b0000;
        operand_a = 32'h1111_1111;
        operand_b = 32'h2222_2222;
        #1;
        check("reset_q", alu_data_q, 32'h0);
        check("reset_comb", alu_data, 32'h3333_3333);
        repeat (2) @(posedge clk);
        #1;
        check("reset_q_held", alu_data_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("add",         4'b0000, 32'h10,        32'h20,        32'h30);
        run_vec("sub",         4'b1000, 32'h30,        32'h10,        32'h20);
        run_vec("add_wrap",    4'b0000, 32'hFFFF_FFFF, 32'h1,         32'h0);
        run_vec("sub_wrap",    4'b1000, 32'h0,         32'h1,         32'hFFFF_FFFF);
        run_vec("sll",         4'b0001, 32'h1,         32'h2,         32'h4);
        run_vec("srl",         4'b0101, 32'h10,        32'h2,         32'h4);
        run_vec("sra_neg",     4'b1101, 32'h8000_0000, 32'h2,         32'hE000_0000);
        run_vec("sra_pos",     4'b1101, 32'h4000_0000, 32'h2,         32'h1000_0000);
        run_vec("sll_hi_b",    4'b0001, 32'h1,         32'h22,        32'h4);
        run_vec("srl_hi_b",    4'b0101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1);
        run_vec("sll_31",      4'b0001, 32'h3,         32'h1F,        32'h8000_0000);
        run_vec("slt",         4'b0010, 32'h1,         32'h2,         32'h1);
        run_vec("slt_neg",     4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h1);
        run_vec("slt_pos_neg", 4'b0010, 32'h1,         32'hFFFF_FFFF, 32'h0);
        run_vec("sltu",        4'b0011, 32'hFFFF_FFFF, 32'h1,         32'h0);
        run_vec("sltu_lt",     4'b0011, 32'h1,         32'hFFFF_FFFF, 32'h1);
        run_vec("slt_eq",      4'b0010, 32'h1234_5678, 32'h1234_5678, 32'h0);
        run_vec("sltu_eq",     4'b0011, 32'h8000_0000, 32'h8000_0000, 32'h0);
        run_vec("xor",         4'b0100, 32'h0F,        32'hF0,        32'hFF);
        run_vec("or",          4'b0110, 32'h0F,        32'hF0,        32'hFF);
        run_vec("and",         4'b0111, 32'hFF,        32'hF0,        32'hF0);
        run_vec("lui",         4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678);
        run_vec("undef_1010",  4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        run_vec("undef_1110",  4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);

        // Mid-run reset: register clears at once while the combinational path keeps working.
        @(negedge clk);
        alu_op    = 4'b0110;
        operand_a = 32'hA5A5_0000;
        operand_b = 32'h0000_5A5A;
        @(posedge clk);
        #1;
        check("pre_reset_q", alu_data_q, 32'hA5A5_5A5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_q", alu_data_q, 32'h0);
        check("comb_in_reset", alu_data, 32'hA5A5_5A5A);
        @(posedge clk);
        #1;
        check("reset_held_q", alu_data_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_q", alu_data_q, 32'hA5A5_5A5A);

        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = pick_operand();
            b  = ($urandom_range(0, 7) == 0) ? a : pick_operand();
            expected = ref_alu(op, a, b);
            run_vec($sformatf("rand%0d_op%04b", i, op), op, a, b, expected);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
